// File: rtl/memory_seq_gen.sv
// memory_seq_gen: pseudo-random sequence generator for a memory game.
// On a rising edge of go it produces SEQ_LEN values from a 5-bit LFSR, displays each
// one for SHOW_TICKS cycles on cur_val (with BCD digits), stores them, and then
// raises done. The stored values can be read back through a registered read port.
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   rst      in   asynchronous reset, active-high
//   go       in   start request (level; rising edge detected internally)
//   rd_addr  in   read index into the stored sequence
//   rd_data  out  stored value at rd_addr, one cycle latency (0 when out of range)
//   cur_val  out  value currently displayed (0 when not showing)
//   ones     out  BCD units digit of cur_val
//   tens     out  BCD tens digit of cur_val
//   show     out  high while a value is being displayed
//   idx      out  index of the value currently displayed
//   done     out  sequence complete and stored
module memory_seq_gen #(
  parameter int unsigned SHOW_TICKS = 50000000,
  parameter int unsigned SEQ_LEN    = 10,
  parameter logic [4:0]  SEED       = 5'b10101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] rd_addr,
  output logic [4:0] rd_data,
  output logic [4:0] cur_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       show,
  output logic [3:0] idx,
  output logic       done
);

  localparam int unsigned     CntW      = $clog2(SHOW_TICKS + 1);
  localparam logic [CntW-1:0] CntReload = CntW'(SHOW_TICKS - 1);
  localparam logic [3:0]      LastIdx   = 4'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StDone
  } state_e;

  state_e          state_q;
  logic [4:0]      lfsr_q;
  logic [4:0]      lfsr_next;
  logic [CntW-1:0] cnt_q;
  logic            go_q;
  logic            arm_q;
  logic            go_edge;
  logic [4:0]      mem_q [SEQ_LEN];
  logic [4:0]      rd_mux;

  // Feedback taps 4 and 2 give a maximal-length sequence, so zero is never reached.
  assign lfsr_next = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};

  // arm_q stays low for the first clock after reset so that a go already high at
  // reset release is not mistaken for a rising edge.
  assign go_edge = go & ~go_q & arm_q;

  assign tens = 4'(cur_val / 5'd10);
  assign ones = 4'(cur_val % 5'd10);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < int'(SEQ_LEN); i++) begin
      if (rd_addr == 4'(i)) begin
        rd_mux = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      arm_q   <= 1'b0;
      rd_data <= '0;
      cur_val <= '0;
      show    <= 1'b0;
      idx     <= '0;
      done    <= 1'b0;
      for (int i = 0; i < int'(SEQ_LEN); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      go_q    <= go;
      arm_q   <= 1'b1;
      rd_data <= rd_mux;

      unique case (state_q)
        StIdle, StDone: begin
          if (go_edge) begin
            for (int i = 0; i < int'(SEQ_LEN); i++) begin
              mem_q[i] <= '0;
            end
            mem_q[0] <= lfsr_next;
            lfsr_q   <= lfsr_next;
            cur_val  <= lfsr_next;
            idx      <= '0;
            show     <= 1'b1;
            done     <= 1'b0;
            cnt_q    <= CntReload;
            state_q  <= StShow;
          end
        end

        StShow: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (idx != LastIdx) begin
            for (int i = 1; i < int'(SEQ_LEN); i++) begin
              if (4'(i) == idx + 4'd1) begin
                mem_q[i] <= lfsr_next;
              end
            end
            idx     <= idx + 4'd1;
            lfsr_q  <= lfsr_next;
            cur_val <= lfsr_next;
            cnt_q   <= CntReload;
          end else begin
            show    <= 1'b0;
            done    <= 1'b1;
            cur_val <= '0;
            state_q <= StDone;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_seq_gen.sv
module tb_memory_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: SHOW_TICKS=4, SEQ_LEN=10
  logic       rst, go;
  logic [3:0] rd_addr;
  logic [4:0] rd_data, cur_val;
  logic [3:0] ones, tens, idx;
  logic       show, done;

  // DUT B: SHOW_TICKS=1, SEQ_LEN=1
  logic       rst_b, go_b;
  logic [3:0] rd_addr_b;
  logic [4:0] rd_data_b, cur_val_b;
  logic [3:0] ones_b, tens_b, idx_b;
  logic       show_b, done_b;

  memory_seq_gen #(.SHOW_TICKS(4), .SEQ_LEN(10), .SEED(5'b10101)) dut_a (
    .clk(clk), .rst(rst), .go(go), .rd_addr(rd_addr), .rd_data(rd_data),
    .cur_val(cur_val), .ones(ones), .tens(tens), .show(show), .idx(idx), .done(done)
  );

  memory_seq_gen #(.SHOW_TICKS(1), .SEQ_LEN(1), .SEED(5'b10101)) dut_b (
    .clk(clk), .rst(rst_b), .go(go_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .cur_val(cur_val_b), .ones(ones_b), .tens(tens_b), .show(show_b), .idx(idx_b),
    .done(done_b)
  );

  typedef struct {
    logic [4:0] val;
    logic [3:0] tens;
    logic [3:0] ones;
  } vec_t;

  vec_t       tbl [10];
  logic [4:0] exp_v [10];
  logic [4:0] m_lfsr;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] lfsr_step(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  // Caller sets go=1 beforehand; the next edge is the go edge (c=0).
  // go is dropped at c==drop_at and raised again at c==rise_at.
  task automatic run_seq(input int drop_at, input int rise_at, input int abort_at);
    int k;
    tick();
    for (int c = 0; c < 40; c++) begin
      if (c == abort_at) return;
      k = c / 4;
      chk($sformatf("cur_val c%0d", c), cur_val, exp_v[k]);
      chk($sformatf("tens c%0d", c), tens, exp_v[k] / 10);
      chk($sformatf("ones c%0d", c), ones, exp_v[k] % 10);
      chk($sformatf("idx c%0d", c), idx, k);
      chk($sformatf("show c%0d", c), show, 1);
      chk($sformatf("done c%0d", c), done, 0);
      if (c == drop_at) go = 1'b0;
      if (c == rise_at) go = 1'b1;
      tick();
    end
    chk("done at 40", done, 1);
    chk("show at 40", show, 0);
    chk("cur_val at 40", cur_val, 0);
    chk("tens at 40", tens, 0);
    chk("ones at 40", ones, 0);
    chk("idx at 40", idx, 9);
  endtask

  initial begin
    // Hand-computed LFSR sequence from seed 10101.
    tbl[0] = '{5'd10, 4'd1, 4'd0};
    tbl[1] = '{5'd20, 4'd2, 4'd0};
    tbl[2] = '{5'd8,  4'd0, 4'd8};
    tbl[3] = '{5'd16, 4'd1, 4'd6};
    tbl[4] = '{5'd1,  4'd0, 4'd1};
    tbl[5] = '{5'd2,  4'd0, 4'd2};
    tbl[6] = '{5'd4,  4'd0, 4'd4};
    tbl[7] = '{5'd9,  4'd0, 4'd9};
    tbl[8] = '{5'd18, 4'd1, 4'd8};
    tbl[9] = '{5'd5,  4'd0, 4'd5};

    rst = 1'b1; go = 1'b0; rd_addr = '0;
    rst_b = 1'b1; go_b = 1'b0; rd_addr_b = '0;
    tick();
    tick();

    // ---------------- DUT B: single value, single tick ----------------
    rst_b = 1'b0;
    tick();
    go_b = 1'b1;
    tick();
    chk("b cur_val first", cur_val_b, 10);
    chk("b show first", show_b, 1);
    chk("b tens first", tens_b, 1);
    chk("b ones first", ones_b, 0);
    chk("b done first", done_b, 0);
    go_b = 1'b0;
    tick();
    chk("b done after 1", done_b, 1);
    chk("b show after 1", show_b, 0);
    chk("b cur_val after 1", cur_val_b, 0);
    tick();
    go_b = 1'b1;
    tick();
    chk("b cur_val second", cur_val_b, 20);
    chk("b show second", show_b, 1);
    tick();
    chk("b done second", done_b, 1);
    rd_addr_b = 4'd0;
    tick();
    chk("b rd_data 0", rd_data_b, 20);
    rd_addr_b = 4'd5;
    tick();
    chk("b rd_data oob", rd_data_b, 0);

    // ---------------- DUT A: reset state ----------------
    chk("reset cur_val", cur_val, 0);
    chk("reset show", show, 0);
    chk("reset done", done, 0);
    chk("reset idx", idx, 0);
    chk("reset rd_data", rd_data, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle show", show, 0);

    // ---------------- Run 1: nominal sequence ----------------
    for (int i = 0; i < 10; i++) exp_v[i] = tbl[i].val;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tbl digits %0d", i), {tbl[i].tens, tbl[i].ones},
          {4'(exp_v[i] / 10), 4'(exp_v[i] % 10)});
    end
    m_lfsr = 5'b10101;
    for (int i = 0; i < 10; i++) m_lfsr = lfsr_step(m_lfsr);
    go = 1'b1;
    run_seq(0, -1, -1);

    // Readback of stored sequence.
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a);
      tick();
      chk($sformatf("rd_data %0d", a), rd_data, tbl[a].val);
    end
    rd_addr = 4'd12;
    tick();
    chk("rd_data 12", rd_data, 0);
    rd_addr = 4'd15;
    tick();
    chk("rd_data 15", rd_data, 0);

    // ---------------- Run 2: go re-pulsed at idx=3, then held ----------------
    for (int i = 0; i < 10; i++) begin
      m_lfsr = lfsr_step(m_lfsr);
      exp_v[i] = m_lfsr;
    end
    chk("model run2 first", exp_v[0], 11);
    go = 1'b1;
    run_seq(13, 14, -1);
    // go still high since c=14; no restart while held.
    for (int c = 0; c < 60; c++) begin
      tick();
      chk($sformatf("held done %0d", c), done, 1);
      chk($sformatf("held show %0d", c), show, 0);
    end
    go = 1'b0;
    tick();
    chk("release done", done, 1);
    chk("release cur_val", cur_val, 0);

    // ---------------- Run 3: reset at idx=5 mid-count ----------------
    for (int i = 0; i < 10; i++) begin
      m_lfsr = lfsr_step(m_lfsr);
      exp_v[i] = m_lfsr;
    end
    rd_addr = 4'd0;
    go = 1'b1;
    run_seq(0, -1, 21);
    chk("pre-reset idx", idx, 5);
    chk("pre-reset rd_data", rd_data, exp_v[0]);
    rst = 1'b1;
    go = 1'b1;
    #1;
    chk("async cur_val", cur_val, 0);
    chk("async ones", ones, 0);
    chk("async tens", tens, 0);
    chk("async show", show, 0);
    chk("async idx", idx, 0);
    chk("async done", done, 0);
    chk("async rd_data", rd_data, 0);
    tick();
    tick();
    rst = 1'b0;
    // go held high across reset release must not start a sequence.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post-rst show %0d", c), show, 0);
      chk($sformatf("post-rst cur_val %0d", c), cur_val, 0);
      chk($sformatf("post-rst rd_data %0d", c), rd_data, 0);
    end
    go = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) exp_v[i] = tbl[i].val;
    go = 1'b1;
    run_seq(0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_seq_gen.md
MEMORY_SEQ_GEN -- requirements
Module: memory_seq_gen

Interface
REQ-001 The block SHALL have these parameters:
- SHOW_TICKS, default 50000000: clock cycles each value is displayed (minimum 1).
- SEQ_LEN, default 10: number of values per sequence (range 1..16).
- SEED, default 5'b10101: LFSR reset value (must be nonzero).

REQ-002 The block SHALL have these ports, one clock and asynchronous active-high reset:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- go  input  1  start request; synchronous, level, rising edge detected internally.
- rd_addr  input  4  checker read index.
- rd_data  output  5  stored value at rd_addr.
- cur_val  output  5  value currently displayed.
- ones  output  4  BCD units digit of cur_val.
- tens  output  4  BCD tens digit of cur_val.
- show  output  1  high while a value is being displayed.
- idx  output  4  index of the value currently displayed.
- done  output  1  sequence complete and stored.

Function
REQ-003 The block SHALL hold a 5-bit LFSR that steps as next = {lfsr[3:0], lfsr[4]^lfsr[2]}, and only when a value is captured.
- The LFSR SHALL never reach zero.
- The LFSR SHALL NOT be reinitialised between sequences, only by rst.

REQ-004 The FSM SHALL have three states: IDLE, SHOW, DONE. It SHALL enter IDLE on reset.

REQ-005 A go edge SHALL be go=1 in the current cycle and go=0 in the previous cycle, where the previous-cycle register resets to 0.

REQ-006 A go edge in IDLE or DONE SHALL start a sequence in the same clock edge:
- clear all SEQ_LEN storage entries to 0
- step the LFSR and write the new value to cur_val and mem[0]
- set idx=0, show=1, done=0
- load the tick counter with SHOW_TICKS-1
- enter SHOW

REQ-007 In SHOW the tick counter SHALL decrement each cycle.
- At count 0 with idx<SEQ_LEN-1: increment idx, step the LFSR, capture the new value into cur_val and mem[idx+1], and reload the counter.
- As a result, each value is visible for exactly SHOW_TICKS cycles.

REQ-008 At count 0 with idx=SEQ_LEN-1, the block SHALL enter DONE next cycle with show=0, done=1, cur_val=0.
- idx SHALL hold SEQ_LEN-1.
- done SHALL stay 1 until the next go edge or reset.

REQ-009 go edges during SHOW SHALL be ignored. A held-high go SHALL NOT retrigger.

REQ-010 ones and tens SHALL be combinational from cur_val:
- tens = cur_val/10 (range 0..3)
- ones = cur_val mod 10

REQ-011 rd_data SHALL be registered with 1-cycle latency and equal mem[rd_addr].
- rd_addr>=SEQ_LEN SHALL read 0.
- Entries not yet written in the current sequence SHALL read 0.

REQ-012 With SHOW_TICKS=1, each value SHALL be shown exactly one cycle. The whole sequence SHALL then take SEQ_LEN cycles from the go edge to DONE.

REQ-013 All counter and index arithmetic SHALL be unsigned.
- The tick counter SHALL be ceil(log2(SHOW_TICKS+1)) bits wide.
- No wrap-around beyond the stated states is permitted.

Reset
REQ-014 rst=1 at any time, including mid-SHOW, SHALL immediately force:
- state IDLE, lfsr=SEED, all mem=0, rd_data=0, cur_val=0
- ones=0, tens=0, show=0, idx=0, done=0, tick counter=0
- go-edge register=0

REQ-015 After rst deasserts, the block SHALL stay in IDLE until a go edge. A go already high at deassertion SHALL NOT count as an edge.

Verification
REQ-016 SEED=10101, SHOW_TICKS=4, SEQ_LEN=10, reset then go edge.
- Required: cur_val=10 (tens=1, ones=0) for 4 cycles, then 20, 8, 16, 1 in order, each for 4 cycles.
- Required: done=1 exactly 40 cycles after the go edge.

REQ-017 After REQ-016 completes, rd_addr=0..9.
- Required: rd_data one cycle later equals the displayed sequence in order.
- Required: rd_addr=12 returns 0.

REQ-018 Go pulsed again mid-SHOW (idx=3), and go held high for 100 cycles.
- Required: sequence timing unchanged.
- Required: no restart.
- Required: exactly one sequence per rising edge.

REQ-019 rst asserted at idx=5 mid-count.
- Required: all outputs 0 in the same cycle.
- Required: a new go edge then starts again at cur_val=10.

REQ-020 SHOW_TICKS=1, SEQ_LEN=1.
- Required: show=1 for one cycle with cur_val=10, then done=1.
- Required: a second go edge yields cur_val=20 (LFSR not reseeded).
